ofdm_sym_sched: RTL
===================

Name: ofdm_sym_sched

Overview:
- Symbol-slot scheduler in front of the cyclic-prefix/windowing stage of the OFDM transmitter.
- Arbitrates between two 64-sample symbol sources: src0 (training/preamble ROM) and src1 (IFFT data path). Grants one whole symbol at a time.
- Paces granted symbols at one symbol per SYM_LEN+CP_LEN cycles, so the CP stage's 80-sample output never overruns.
- Drives the CP stage's sample/enable/index inputs. Holds a safe index value between symbols.

Parameters:
- DW, 8, sample width per I/Q component
- SYM_LEN, 64, samples per symbol (power of 2)
- CP_LEN, 16, gap cycles inserted after each burst
- IDLE_IDX, 1, din_index value driven when no burst is active; must not be 0, 48..63 or SYM_LEN-2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s0_req  in  1  src0 has a symbol ready
- s0_re / s0_im  in  DW  src0 sample
- s0_vld  in  1  src0 sample valid
- s0_gnt  out  1  src0 burst active; source must present one sample per cycle while high
- s1_req, s1_re, s1_im, s1_vld, s1_gnt  same as src0, for src1
- din_re / din_im  out  DW  sample to CP stage
- din_en  out  1  sample valid to CP stage
- din_index  out  log2(SYM_LEN)  sample index within symbol
- src_sel  out  1  source of current/last burst (0 = src0)
- underflow  out  1  one-cycle pulse: granted source had vld=0 on a burst cycle
- sym_cnt  out  16  symbols issued; wraps 65535 -> 0

Behaviour:
- Reset values: all outputs 0, except din_index = IDLE_IDX. State IDLE, counters 0.
- States and transitions:
  - IDLE -> BURST on the cycle after any req is sampled high.
  - BURST lasts exactly SYM_LEN cycles, then goes to GAP.
  - GAP lasts exactly CP_LEN cycles. At its last cycle, go to BURST if any req is high (back-to-back symbols at a pitch of SYM_LEN+CP_LEN = 80 cycles); otherwise go to IDLE.
- Arbitration:
  - req is sampled only in IDLE and on the last GAP cycle.
  - Fixed priority: src0 wins over src1 (see Optional Feature for the alternative).
  - The winner is latched into src_sel for the whole burst.
- Grant: sX_gnt is high for exactly the SYM_LEN BURST cycles of the winner. It is never high for both sources at once.
- Datapath:
  - The sample presented on a gnt cycle k appears registered on din_* at k+1.
  - din_en = 1 and din_index = 0..SYM_LEN-1 in order.
  - The pipeline latency is fixed at one cycle.
- Underflow:
  - On a gnt cycle with vld=0: the output sample is forced to 0, din_en is still 1, the index still advances, and underflow pulses in the same cycle the zero sample is output.
  - The burst is never stretched.
- Non-burst output: when not outputting a burst sample, din_en = 0, din_re/din_im = 0 and din_index = IDLE_IDX. This prevents spurious first-sample capture or buffer toggling in the CP stage.
- req changes:
  - req dropping mid-burst does not abort the burst.
  - req rising mid-burst or mid-GAP waits for the next arbitration point.
- sym_cnt increments on the cycle din_index = SYM_LEN-1 is output.
- Reset mid-burst: immediate return to reset values. The partial symbol is discarded and the next burst restarts at index 0.

Optional Feature:
- Macro: OFDM_SCHED_RR_EN.
- Defined: round-robin arbitration. If both reqs are high, the source that did not win the previous burst is granted. After reset, src0 has priority.
- Undefined: fixed src0 priority. src1 can be starved while s0_req stays high.

Decomposition:
- Shared package ofdm_sched_pkg holds:
  - SYM_LEN and CP_LEN defaults
  - the IDX_W = log2(SYM_LEN) function
  - the state enum {IDLE, BURST, GAP}
- One sub-module, ofdm_sched_arb: a 2-requester arbiter with sample-enable input, priority/RR logic under the macro, and a registered winner output.

Test Plan:
- Single symbol: s1_req high 1 cycle in IDLE, s1 presents ramp 0..63 with vld=1 -> s1_gnt high 64 cycles; din_re = 0..63 one cycle later, din_index = 0..63; din_index returns to 1 afterwards; sym_cnt = 1.
- Back-to-back: s1_req held high for 3 symbols -> din_en bursts of 64, period exactly 80 cycles, 16 idle cycles between bursts, sym_cnt = 3.
- Contention, macro undefined: s0_req and s1_req high together -> src0 wins every slot, src_sel = 0. Macro defined -> grants alternate 0,1,0,1.
- Underflow: s1_vld=0 on burst cycle 10 only -> din at index 10 is 0/0 with din_en = 1, underflow pulses once, burst still ends at index 63.
- Late req: s0_req rises on GAP cycle 5 while src1 is streaming -> s0 granted at the next slot boundary, 80 cycles after the prior burst start.
- Reset at din_index = 30 -> all outputs return to reset values asynchronously; the next req produces a burst starting at index 0 and sym_cnt restarts from 0.

Source files
------------

// File: rtl/ofdm_sched_pkg.sv
// Shared defaults, index-width helper and FSM state type for the OFDM symbol scheduler.
package ofdm_sched_pkg;

    localparam int SYM_LEN_DEF = 64;
    localparam int CP_LEN_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic int idx_w(input int sym_len);
        return $clog2(sym_len);
    endfunction

endpackage

// File: rtl/ofdm_sched_arb.sv
// Two-requester arbiter with sample enable and registered winner.
// OFDM_SCHED_RR_EN selects round-robin; otherwise src0 has fixed priority.
module ofdm_sched_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic       winner
);

    logic winner_reg;
    logic pick;

`ifdef OFDM_SCHED_RR_EN
    // prio_reg names the source that wins a tie; it starts at src0
    logic prio_reg;

    assign pick = (&req) ? prio_reg : req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= 1'b0;
        end else if (en && (|req)) begin
            prio_reg <= ~pick;
        end
    end
`else
    assign pick = ~req[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_reg <= 1'b0;
        end else if (en && (|req)) begin
            winner_reg <= pick;
        end
    end

    assign winner = winner_reg;

endmodule

// File: rtl/ofdm_sym_sched.sv
// Symbol-slot scheduler feeding the CP/windowing stage: grants whole symbols and
// paces them at SYM_LEN+CP_LEN cycles. Arbitration mode set by OFDM_SCHED_RR_EN.
module ofdm_sym_sched
    import ofdm_sched_pkg::*;
#(
    parameter int DW       = 8,
    parameter int SYM_LEN  = SYM_LEN_DEF,
    parameter int CP_LEN   = CP_LEN_DEF,
    parameter int IDLE_IDX = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s0_req,
    input  logic [DW-1:0]               s0_re,
    input  logic [DW-1:0]               s0_im,
    input  logic                        s0_vld,
    output logic                        s0_gnt,
    input  logic                        s1_req,
    input  logic [DW-1:0]               s1_re,
    input  logic [DW-1:0]               s1_im,
    input  logic                        s1_vld,
    output logic                        s1_gnt,
    output logic [DW-1:0]               din_re,
    output logic [DW-1:0]               din_im,
    output logic                        din_en,
    output logic [idx_w(SYM_LEN)-1:0]   din_index,
    output logic                        src_sel,
    output logic                        underflow,
    output logic [15:0]                 sym_cnt
);

    localparam int IDX_W = idx_w(SYM_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_GAP = IDX_W'(CP_LEN - 1);
    localparam logic [IDX_W-1:0] IDLE_VAL = IDX_W'(IDLE_IDX);

    state_t           state_reg;
    logic [IDX_W-1:0] cnt_reg;
    logic             winner;
    logic             arb_en;
    logic             any_req;
    logic             in_burst;

    logic [1:0]    req_vec;
    logic [1:0]    vld_vec;
    logic [1:0]    gnt_vec;
    logic [1:0]    ok_vec;
    logic [DW-1:0] re_vec [2];
    logic [DW-1:0] im_vec [2];
    logic [DW-1:0] re_msk [2];
    logic [DW-1:0] im_msk [2];
    logic [DW-1:0] din_re_next;
    logic [DW-1:0] din_im_next;
    logic          underflow_next;

    logic [DW-1:0]    din_re_reg;
    logic [DW-1:0]    din_im_reg;
    logic             din_en_reg;
    logic [IDX_W-1:0] din_index_reg;
    logic             underflow_reg;
    logic [15:0]      sym_cnt_reg;

    assign req_vec   = {s1_req, s0_req};
    assign vld_vec   = {s1_vld, s0_vld};
    assign re_vec[0] = s0_re;
    assign re_vec[1] = s1_re;
    assign im_vec[0] = s0_im;
    assign im_vec[1] = s1_im;
    assign any_req   = |req_vec;
    assign in_burst  = (state_reg == BURST);

    // Requests are only looked at in IDLE and on the final gap cycle
    assign arb_en = (state_reg == IDLE) || ((state_reg == GAP) && (cnt_reg == LAST_GAP));

    ofdm_sched_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (arb_en),
        .req    (req_vec),
        .winner (winner)
    );

    assign gnt_vec = in_burst ? (winner ? 2'b10 : 2'b01) : 2'b00;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign ok_vec[gi] = gnt_vec[gi] & vld_vec[gi];
            assign re_msk[gi] = ok_vec[gi] ? re_vec[gi] : '0;
            assign im_msk[gi] = ok_vec[gi] ? im_vec[gi] : '0;
        end
    endgenerate

    // Grants are one-hot, so OR-ing the masked samples is a clean mux
    assign din_re_next    = re_msk[0] | re_msk[1];
    assign din_im_next    = im_msk[0] | im_msk[1];
    assign underflow_next = in_burst & ~(|ok_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (any_req) begin
                        state_reg <= BURST;
                    end
                end
                BURST: begin
                    if (cnt_reg == LAST_IDX) begin
                        state_reg <= GAP;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == LAST_GAP) begin
                        state_reg <= any_req ? BURST : IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_re_reg    <= '0;
            din_im_reg    <= '0;
            din_en_reg    <= 1'b0;
            din_index_reg <= IDLE_VAL;
            underflow_reg <= 1'b0;
            sym_cnt_reg   <= '0;
        end else begin
            din_re_reg    <= din_re_next;
            din_im_reg    <= din_im_next;
            din_en_reg    <= in_burst;
            din_index_reg <= in_burst ? cnt_reg : IDLE_VAL;
            underflow_reg <= underflow_next;
            if (in_burst && (cnt_reg == LAST_IDX)) begin
                sym_cnt_reg <= sym_cnt_reg + 16'd1;
            end
        end
    end

    assign s0_gnt    = gnt_vec[0];
    assign s1_gnt    = gnt_vec[1];
    assign src_sel   = winner;
    assign din_re    = din_re_reg;
    assign din_im    = din_im_reg;
    assign din_en    = din_en_reg;
    assign din_index = din_index_reg;
    assign underflow = underflow_reg;
    assign sym_cnt   = sym_cnt_reg;

endmodule
